// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI codes, FSM state types and burst legality helper for the
// memory responder.
package axi_mem_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXSIZE_64   = 3'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Only full-width INCR bursts touch the RAM; anything else runs as a dummy burst.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    logic legal;
    case (burst)
      BURST_INCR:              legal = (size == AXSIZE_64);
      BURST_FIXED, BURST_WRAP: legal = 1'b0;
      default:                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Flop-array RAM: one byte-masked synchronous write port and one
// combinational read port; contents are never reset.
module axi_mem_responder_ram #(
  parameter int els_p   = 1024,
  parameter int width_p = 64,
  parameter int idx_w_p = $clog2(els_p)
) (
  input  logic                 clk,
  input  logic                 w_en,
  input  logic [idx_w_p-1:0]   w_idx,
  input  logic [width_p-1:0]   w_data,
  input  logic [width_p/8-1:0] w_strb,
  input  logic [idx_w_p-1:0]   r_idx,
  output logic [width_p-1:0]   r_data
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int b = 0; b < width_p/8; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  assign r_data = mem[r_idx];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR burst memory slave: independent single-outstanding write and
// read FSMs in front of a byte-writable RAM, with ID echo and SLVERR on bad bursts.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  parameter int id_width_p   = 6,
  parameter int mem_els_p    = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [addr_width_p-1:0]   s_axi_awaddr,
  input  logic [id_width_p-1:0]     s_axi_awid,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awqos,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,

  input  logic [id_width_p-1:0]     s_axi_wid,
  input  logic [data_width_p-1:0]   s_axi_wdata,
  input  logic [data_width_p/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,

  output logic [id_width_p-1:0]     s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,

  input  logic [addr_width_p-1:0]   s_axi_araddr,
  input  logic [id_width_p-1:0]     s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arqos,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,

  output logic [data_width_p-1:0]   s_axi_rdata,
  output logic [id_width_p-1:0]     s_axi_rid,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam logic [idx_w_lp-1:0] idx_one_lp = 1;

  w_state_t              w_state;
  logic [idx_w_lp-1:0]   w_idx;
  logic [7:0]            w_cnt;
  logic                  w_legal;
  logic                  w_err;

  r_state_t              r_state;
  logic [idx_w_lp-1:0]   r_idx;
  logic [7:0]            r_cnt;
  logic                  r_legal;

  logic [idx_w_lp-1:0]   aw_idx;
  logic [idx_w_lp-1:0]   ar_idx;
  logic                  aw_legal;
  logic                  ar_legal;
  logic                  w_beat;
  logic                  ram_we;
  logic [idx_w_lp-1:0]   ram_r_idx;
  logic [data_width_p-1:0] ram_rdata;
  logic                  unused_ok;

  assign aw_idx   = s_axi_awaddr[3 +: idx_w_lp];
  assign ar_idx   = s_axi_araddr[3 +: idx_w_lp];
  assign aw_legal = burst_legal(s_axi_awburst, s_axi_awsize);
  assign ar_legal = burst_legal(s_axi_arburst, s_axi_arsize);
  assign w_beat   = (w_state == W_DATA) && s_axi_wready && s_axi_wvalid;
  assign ram_we   = w_beat && w_legal;
  // In R_DATA, r_idx already points at the beat after the one on the bus.
  assign ram_r_idx = (r_state == R_IDLE) ? ar_idx : r_idx;

  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_awlock, s_axi_awcache,
                       s_axi_awprot, s_axi_awqos, s_axi_arlock, s_axi_arcache,
                       s_axi_arprot, s_axi_arqos, s_axi_wid};

  axi_mem_responder_ram #(
    .els_p   (mem_els_p),
    .width_p (data_width_p),
    .idx_w_p (idx_w_lp)
  ) u_ram (
    .clk    (aclk),
    .w_en   (ram_we),
    .w_idx  (w_idx),
    .w_data (s_axi_wdata),
    .w_strb (s_axi_wstrb),
    .r_idx  (ram_r_idx),
    .r_data (ram_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_idx         <= '0;
      w_cnt         <= '0;
      w_legal       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!s_axi_awready) begin
            s_axi_awready <= 1'b1;
          end else if (s_axi_awvalid) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_idx         <= aw_idx;
            w_cnt         <= s_axi_awlen;
            w_legal       <= aw_legal;
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          // The beat count ends the burst; a misplaced wlast only taints the response.
          if (s_axi_wvalid) begin
            w_idx <= w_idx + idx_one_lp;
            w_cnt <= w_cnt - 8'd1;
            if (w_cnt == 8'd0) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_legal && !w_err && s_axi_wlast) ? RESP_OKAY : RESP_SLVERR;
              w_state      <= W_RESP;
            end else if (s_axi_wlast) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_legal       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!s_axi_arready) begin
            s_axi_arready <= 1'b1;
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            s_axi_rdata   <= ar_legal ? ram_rdata : '0;
            r_idx         <= ar_idx + idx_one_lp;
            r_cnt         <= s_axi_arlen;
            r_legal       <= ar_legal;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_cnt == 8'd0) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_rdata   <= '0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rlast <= (r_cnt == 8'd1);
              s_axi_rdata <= r_legal ? ram_rdata : '0;
              r_idx       <= r_idx + idx_one_lp;
              r_cnt       <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected B/R beats are queued when a
// burst is issued and popped as the responder hands them back.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam int MEM_ELS = 1024;

  logic        aclk;
  logic        aresetn;
  logic [31:0] awaddr, araddr;
  logic [5:0]  awid, arid, wid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, arvalid, awready, arready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic [63:0] rdata;
  logic        rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  logic [63:0] model_mem [MEM_ELS];

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [5:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];

  axi_mem_responder dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awid    (awid),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awlock  (1'b0),
    .s_axi_awcache (4'h3),
    .s_axi_awprot  (3'h0),
    .s_axi_awqos   (4'h0),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wid     (wid),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arid    (arid),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arlock  (1'b0),
    .s_axi_arcache (4'h3),
    .s_axi_arprot  (3'h0),
    .s_axi_arqos   (4'h0),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rid     (rid),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Issues one write burst, updates the reference memory and checks the B response.
  task automatic drive_write(input logic [31:0] addr, input logic [5:0] id, input int len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [63:0] base, input logic [7:0] strb,
                             input int wlast_beat, input int bdelay);
    bit legal;
    int idx, cnt;
    logic [63:0] w;
    bexp_t exp_b;
    legal = (burst == 2'b01) && (size == 3'd3);
    exp_b.id = id;
    exp_b.resp = (legal && wlast_beat == len) ? 2'b00 : 2'b10;
    bq.push_back(exp_b);
    idx = int'(addr[12:3]);
    if (legal) begin
      for (int i = 0; i <= len; i++) begin
        w = base + 64'(i);
        for (int b = 0; b < 8; b++)
          if (strb[b]) model_mem[(idx + i) % MEM_ELS][8*b +: 8] = w[8*b +: 8];
      end
    end
    awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (awready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    checks++;
    if (awready !== 1'b1) begin errors++; $display("[TB] FAIL aw_handshake awready=%b required 1", awready); end
    tick();
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("[TB] FAIL wready_latency wready=%b required 1", wready); end
    for (int i = 0; i <= len; i++) begin
      wdata = base + 64'(i); wstrb = strb; wlast = (i == wlast_beat); wid = id; wvalid = 1'b1;
      cnt = 0;
      while (wready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
      if (wready !== 1'b1) begin
        checks++; errors++;
        $display("[TB] FAIL w_beat_timeout beat=%0d wready=%b required 1", i, wready);
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("[TB] FAIL bvalid_latency bvalid=%b required 1", bvalid); end
    for (int d = 0; d < bdelay; d++) begin
      tick();
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b_hold cycle=%0d bvalid=%b awready=%b required 1/0", d, bvalid, awready);
      end
    end
    bready = 1'b1;
    cnt = 0;
    while (bvalid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    exp_b = bq.pop_front();
    checks++;
    if (bvalid !== 1'b1 || bid !== exp_b.id || bresp !== exp_b.resp) begin
      errors++;
      $display("[TB] FAIL b_response bvalid=%b bid=%h bresp=%b required 1 %h %b",
               bvalid, bid, bresp, exp_b.id, exp_b.resp);
    end
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b_done bvalid=%b awready=%b required 0/1", bvalid, awready);
    end
  endtask

  // Issues one read burst; every cycle with a beat pending compares the bus to the queue head.
  task automatic drive_read(input logic [31:0] addr, input logic [5:0] id, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input bit stall);
    bit legal;
    int idx, cnt, cyc;
    rbeat_t e;
    legal = (burst == 2'b01) && (size == 3'd3);
    idx = int'(addr[12:3]);
    for (int i = 0; i <= len; i++) begin
      e.data = legal ? model_mem[(idx + i) % MEM_ELS] : 64'd0;
      e.last = (i == len);
      e.resp = legal ? 2'b00 : 2'b10;
      e.id   = id;
      rq.push_back(e);
    end
    araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (arready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    checks++;
    if (arready !== 1'b1) begin errors++; $display("[TB] FAIL ar_handshake arready=%b required 1", arready); end
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rvalid_latency rvalid=%b required 1", rvalid); end
    cyc = 0;
    while (rq.size() > 0 && cyc < 100) begin
      rready = stall ? (cyc % 2 == 0) : 1'b1;
      e = rq[0];
      checks++;
      if (rvalid !== 1'b1 || rdata !== e.data || rlast !== e.last || rresp !== e.resp || rid !== e.id) begin
        errors++;
        $display("[TB] FAIL r_beat cyc=%0d got v=%b d=%h l=%b r=%b id=%h required 1 %h %b %b %h",
                 cyc, rvalid, rdata, rlast, rresp, rid, e.data, e.last, e.resp, e.id);
      end
      if (rvalid === 1'b1 && rready) void'(rq.pop_front());
      tick();
      cyc++;
    end
    if (rq.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL r_timeout beats_left=%0d required 0", rq.size());
      rq.delete();
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rdata !== 64'd0 || arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL r_done rvalid=%b rdata=%h arready=%b required 0 0 1", rvalid, rdata, arready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; wlast = 0;
    awaddr = 0; awid = 0; awlen = 0; awsize = 3; awburst = 1;
    araddr = 0; arid = 0; arlen = 0; arsize = 3; arburst = 1;
    wdata = 0; wstrb = 0; wid = 0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 ||
        bid !== 6'd0 || rid !== 6'd0 || bresp !== 2'd0 || rresp !== 2'd0 || rdata !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs rdy/v=%b%b%b%b%b%b bid=%h rid=%h rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, rlast, bid, rid, rdata);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release awready=%b arready=%b required 1/1", awready, arready);
    end
  endtask

  task automatic test_basic_burst();
    drive_write(32'h100, 6'h2A, 3, BURST_INCR, 3'd3, 64'd1, 8'hFF, 3, 0);
    drive_read(32'h100, 6'h15, 3, BURST_INCR, 3'd3, 1'b0);
  endtask

  task automatic test_partial_strobe();
    drive_write(32'h200, 6'h01, 0, BURST_INCR, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    drive_write(32'h200, 6'h02, 0, BURST_INCR, 3'd3, 64'h0, 8'h0F, 0, 0);
    drive_read(32'h200, 6'h03, 0, BURST_INCR, 3'd3, 1'b0);
  endtask

  task automatic test_backpressure();
    drive_write(32'h300, 6'h0C, 7, BURST_INCR, 3'd3, 64'h1234_0000_0000_0300, 8'hFF, 7, 5);
    drive_read(32'h300, 6'h0D, 7, BURST_INCR, 3'd3, 1'b1);
  endtask

  task automatic test_errors();
    drive_write(32'h100, 6'h07, 0, BURST_FIXED, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 0);
    drive_read(32'h100, 6'h08, 0, BURST_INCR, 3'd3, 1'b0);
    drive_read(32'h100, 6'h09, 0, BURST_INCR, 3'd2, 1'b0);
    drive_write(32'h180, 6'h0A, 3, BURST_INCR, 3'd3, 64'h10, 8'hFF, 1, 0);
    drive_read(32'h180, 6'h0B, 3, BURST_INCR, 3'd3, 1'b0);
  endtask

  task automatic test_wrap();
    drive_write(32'h1FF8, 6'h20, 1, BURST_INCR, 3'd3, 64'h5500, 8'hFF, 1, 0);
    drive_read(32'h1FF8, 6'h21, 1, BURST_INCR, 3'd3, 1'b0);
    drive_read(32'h2000, 6'h22, 0, BURST_INCR, 3'd3, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    rbeat_t e;
    int cnt;
    drive_write(32'h400, 6'h30, 7, BURST_INCR, 3'd3, 64'hBEEF_0000, 8'hFF, 7, 0);
    for (int i = 0; i < 8; i++) begin
      e.data = model_mem[128 + i]; e.last = (i == 7); e.resp = 2'b00; e.id = 6'h31;
      rq.push_back(e);
    end
    araddr = 32'h400; arid = 6'h31; arlen = 8'd7; arsize = 3'd3; arburst = BURST_INCR; arvalid = 1'b1;
    cnt = 0;
    while (arready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = rq.pop_front();
      checks++;
      if (rvalid !== 1'b1 || rdata !== e.data || rlast !== e.last) begin
        errors++;
        $display("[TB] FAIL mid_read_beat%0d v=%b d=%h l=%b required 1 %h %b", i, rvalid, rdata, rlast, e.data, e.last);
      end
      tick();
    end
    rready = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 64'd0 || arready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_read_reset rvalid=%b rlast=%b rdata=%h arready=%b required 0 0 0 0",
               rvalid, rlast, rdata, arready);
    end
    rq.delete();
    tick();
    aresetn = 1'b1;
    tick();
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_read_release arready=%b rvalid=%b required 1/0", arready, rvalid);
    end
    drive_read(32'h400, 6'h32, 7, BURST_INCR, 3'd3, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEM_ELS; i++) model_mem[i] = 64'd0;
    test_reset();
    test_basic_burst();
    test_partial_strobe();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 burst memory responder: the slave end of the 64-bit AXI4 memory master port that the FPGA top exposes (m00_axi_*). It accepts INCR read/write bursts, serves them from an internal byte-writable RAM, and returns B/R responses with echoed IDs. It replaces the PS DDR in cosim and standalone FPGA images, so the memory master can be exercised without Zynq hardware.

## Interface
- data_width_p, 64, AXI data width; only 64 supported (awsize/arsize == 3)
- addr_width_p, 32, AXI address width
- id_width_p, 6, AXI ID width
- mem_els_p, 1024, RAM depth in 64-bit words (power of 2)

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axi_aw{addr,id,len,size,burst}, s_axi_awvalid  in  addr_width_p/id_width_p/8/3/2/1  write address channel; awlock/awcache/awprot/awqos accepted and ignored
- s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast/wvalid  in  64/8/1/1  write data; wid ignored
- s_axi_wready  out  1
- s_axi_bid/bresp/bvalid  out  id_width_p/2/1;  s_axi_bready  in  1
- s_axi_ar{addr,id,len,size,burst}, s_axi_arvalid  in  same widths as AW; arlock/arcache/arprot/arqos ignored
- s_axi_arready  out  1
- s_axi_rdata/rid/rresp/rlast/rvalid  out  64/id_width_p/2/1/1;  s_axi_rready  in  1

## Operation
- Write and read paths are independent FSMs, one outstanding burst each; no interleaving, no reordering.
- Word index = addr[3 +: log2(mem_els_p)]; addr[2:0] and bits above the index are ignored (address wraps modulo RAM size). Index increments by 1 per beat, wrapping at mem_els_p-1 -> 0.
- Legal burst: burst == INCR (2'b01) and size == 3. Otherwise the burst is still run for len+1 beats, but no RAM write occurs, read data is 0, and the response is SLVERR (2'b10). Legal bursts respond OKAY (2'b00).
- Write FSM: W_IDLE (awready=1) -> on aw handshake latch id, index, len, legal -> W_DATA (wready=1); each w handshake writes bytes whose wstrb bit is 1, decrements the beat count -> after beat len+1 -> W_RESP (bvalid=1, bid=latched id) -> on bready -> W_IDLE.
- wlast check: if wlast is not 1 exactly on beat len+1, or is 1 on an earlier beat, bresp = SLVERR; the beat count alone ends the burst.
- Read FSM: R_IDLE (arready=1) -> on ar handshake latch id, index, len, legal -> R_DATA (rvalid=1, rid=latched id, rdata = RAM[index], rlast=1 on final beat) -> each r handshake advances; after final beat -> R_IDLE.
- rdata/rresp/rlast stable while rvalid=1 and rready=0; rdata = 0 when rvalid=0.
- Simultaneous write and read to the same word in the same cycle: read returns pre-write data; write commits at the edge.

## Timing
- Reset (aresetn=0, any cycle, including mid-burst): awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0; FSMs to IDLE; burst in flight abandoned. RAM contents not reset.
- First cycle after reset release: awready=1, arready=1.
- AR handshake at cycle N -> first rvalid at N+1; beats back-to-back while rready=1 -> len+1 beats in cycles N+1..N+1+len.
- AW handshake at N -> wready at N+1; last W beat at M -> bvalid at M+1; next awready the cycle after B handshake.
- awready low in W_DATA/W_RESP; arready low in R_DATA. Readies do not depend on valids combinationally.

## Structure
- Shared package axi_mem_responder_pkg: AXI burst codes (FIXED/INCR/WRAP), resp codes (OKAY, SLVERR), write-state and read-state enums, axsize constant 3.
- Sub-module axi_mem_responder_ram: mem_els_p x 64 flop array, one byte-masked synchronous write port, one combinational read port, no reset.

## Test plan
- Reset then write burst addr 0x100, len 3, wstrb 0xFF, data 1..4, wlast on beat 4 -> bresp OKAY, bid echoed; read burst addr 0x100 len 3 -> rdata 1,2,3,4, rlast on beat 4 only, rresp OKAY.
- Partial strobe: word preset 0xFFFF_FFFF_FFFF_FFFF, write 0x0 with wstrb 0x0F -> reads 0xFFFF_FFFF_0000_0000.
- Backpressure: read len 7 with rready toggling 1/0 every cycle -> 8 beats, data/rlast held stable while stalled; bready held 0 for 5 cycles -> bvalid held, awready stays 0.
- Error cases: awburst FIXED -> SLVERR, RAM unchanged; arsize 2 -> 1 beat of rdata 0, SLVERR; wlast on beat 2 of len 3 -> 4 beats accepted, SLVERR.
- Wrap: write len 1 at index mem_els_p-1 -> second beat lands at index 0.
- aresetn asserted mid-read burst (beat 3 of 8) -> rvalid 0 immediately, arready 1 after release, RAM contents intact on re-read.
